// File: rtl/img_mem_arbiter.sv
// Image memory arbiter: copies an image from ROM into RAM after a start pulse,
// then shares the single RAM port between VGA reads (highest priority) and
// processor accesses.
module img_mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int IMG_WORDS = 65536
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_valid,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wd,
  input  logic [DW-1:0] ram_rd,
  output logic          copy_busy,
  output logic          copy_done
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(IMG_WORDS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;
  logic          done_nxt;
  logic          vga_gnt;
  logic          cpu_rd;
  logic          vga_vld_q, cpu_vld_q;
  logic [DW-1:0] vga_hold, cpu_hold;

  // ROM address tracks the copy index; data arrives one cycle later in WRITE.
  assign rom_addr  = idx;
  assign copy_busy = (state == FETCH) || (state == WRITE);

  // State, copy index and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      copy_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      copy_done <= done_nxt;
    end
  end

  // Next-state logic; a VGA request stalls the copy in WRITE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = copy_done;
    case (state)
      IDLE, RUN: begin
        if (start) begin
          state_nxt = FETCH;
          idx_nxt   = '0;
          done_nxt  = 1'b0;
        end
      end
      FETCH: state_nxt = WRITE;
      WRITE: begin
        if (!vga_req) begin
          if (idx == LAST) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FETCH;
            idx_nxt   = idx + AW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port arbitration: VGA, then copy write, then CPU (RUN only).
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_wd   = '0;
    vga_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    if (!reset) begin
      if (vga_req) begin
        vga_gnt  = 1'b1;
        ram_addr = vga_addr;
      end else if (state == WRITE) begin
        ram_addr = idx;
        ram_we   = 1'b1;
        ram_wd   = rom_data;
      end else if (state == RUN && cpu_req) begin
        cpu_gnt  = 1'b1;
        ram_addr = cpu_addr;
        ram_we   = cpu_we;
        ram_wd   = cpu_we ? cpu_wdata : '0;
      end
    end
  end

  assign cpu_rd = cpu_gnt && !cpu_we;

  // Read-data valid flags, one cycle after the grant (RAM read latency).
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_vld_q <= 1'b0;
      cpu_vld_q <= 1'b0;
    end else begin
      vga_vld_q <= vga_gnt;
      cpu_vld_q <= cpu_rd;
    end
  end

  // Capture the returned word so read data holds between valid pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_hold <= '0;
      cpu_hold <= '0;
    end else begin
      if (vga_vld_q) vga_hold <= ram_rd;
      if (cpu_vld_q) cpu_hold <= ram_rd;
    end
  end

  assign vga_valid = vga_vld_q;
  assign cpu_valid = cpu_vld_q;
  assign vga_rdata = vga_vld_q ? ram_rd : vga_hold;
  assign cpu_rdata = cpu_vld_q ? ram_rd : cpu_hold;

endmodule

// File: doc/img_mem_arbiter.md
IMG_MEM_ARBITER -- requirements
Module: img_mem_arbiter

Interface
REQ-001 Parameters SHALL be: AW, 16, address width; DW, 32, data width; IMG_WORDS, 65536, number of words copied from ROM to RAM (range 1..2^AW).
REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse that begins a ROM-to-RAM image copy
- vga_req  in  1  VGA read request
- vga_addr  in  AW  VGA read address
- vga_rdata  out  DW  VGA read data
- vga_valid  out  1  vga_rdata valid pulse
- cpu_req  in  1  processor access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  processor address
- cpu_wdata  in  DW  processor write data
- cpu_gnt  out  1  processor access accepted this cycle
- cpu_rdata  out  DW  processor read data
- cpu_valid  out  1  cpu_rdata valid pulse
- rom_addr  out  AW  image ROM address
- rom_data  in  DW  image ROM data, one-cycle read latency
- ram_addr  out  AW  image RAM address
- ram_we  out  1  image RAM write enable
- ram_wd  out  DW  image RAM write data
- ram_rd  in  DW  image RAM read data, one-cycle read latency
- copy_busy  out  1  copy in progress
- copy_done  out  1  copy completed, level

Function
REQ-003 The FSM SHALL have four states: IDLE, FETCH, WRITE and RUN.
REQ-004 In IDLE, a start pulse SHALL clear the copy index to 0, clear copy_done and move to FETCH; cpu_req SHALL NOT be granted in IDLE.
REQ-005 In FETCH, the block SHALL drive rom_addr=index and move to WRITE on the next cycle.
REQ-006 In WRITE, rom_addr SHALL stay equal to index.
- If vga_req=0: drive ram_addr=index, ram_we=1, ram_wd=rom_data.
- If vga_req=0 and index<IMG_WORDS-1: increment index and go to FETCH.
- If vga_req=0 and index=IMG_WORDS-1: set copy_done=1 and go to RUN.
- If vga_req=1: remain in WRITE with no RAM write (stall).
REQ-007 copy_busy SHALL be 1 exactly in FETCH and WRITE.
REQ-008 During FETCH and WRITE, cpu_gnt SHALL be 0.
REQ-009 In every state, vga_req SHALL have highest priority.
- Grant cycle: ram_addr=vga_addr, ram_we=0.
- Next cycle: vga_rdata=ram_rd, vga_valid=1 for exactly one cycle.
REQ-010 In RUN, when cpu_req=1 and vga_req=0:
- cpu_gnt=1 combinationally, ram_addr=cpu_addr.
- For a write: ram_we=cpu_we, ram_wd=cpu_wdata.
- For a read: cpu_rdata=ram_rd and cpu_valid=1 on the next cycle only.
REQ-011 When vga_req and cpu_req are both 1, cpu_gnt SHALL be 0 and the CPU request SHALL remain pending with no lost or duplicated access.
REQ-012 A start pulse in RUN SHALL restart the copy (index←0, copy_done←0, go to FETCH); a start pulse during FETCH or WRITE SHALL be ignored.
REQ-013 With no grant in a cycle, the block SHALL drive ram_we=0, ram_addr=0 and ram_wd=0.
REQ-014 vga_rdata and cpu_rdata SHALL hold their last value between valid pulses.
REQ-015 At most one RAM access SHALL occur per cycle.

Reset
REQ-016 When reset=1 at a clk edge, the block SHALL enter IDLE from any state, including mid-copy, and set:
- index=0
- copy_busy=0, copy_done=0
- vga_valid=0, cpu_valid=0
- vga_rdata=0, cpu_rdata=0
REQ-017 During reset, cpu_gnt and ram_we SHALL be 0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- IMG_WORDS=4, start, no other requests -> RAM writes at addresses 0,1,2,3 with the ROM contents, one write every 2 cycles; copy_done=1 at cycle 8 after start; state RUN.
- IMG_WORDS=4, vga_req held high for 3 cycles while in WRITE at index 1 -> no RAM write during those cycles; word 1 is written on the first cycle vga_req=0; final RAM contents correct.
- In RUN, cpu write 0xDEADBEEF to address 0x10, then cpu read of 0x10 -> cpu_gnt=1 for each access; cpu_rdata=0xDEADBEEF with cpu_valid=1 one cycle after the read grant.
- In RUN, vga_req and cpu_req asserted in the same cycle -> vga served, cpu_gnt=0; cpu granted the following cycle once vga_req=0; exactly one CPU access performed.
- reset asserted mid-copy at index 2 -> IDLE next cycle, copy_busy=0, copy_done=0; a later start copies again from index 0.
- cpu_req held in IDLE and during the copy -> cpu_gnt stays 0 until RUN.
